// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants, width helper and count type for the FIFO read packer
// Purpose: default parameter values, a constant clog2 for count widths, and the
//          default-sized fill/byte-count type.
// Ports:   none (package).
package fifo_pkg;

    localparam int DEFAULT_WIDTH   = 8;
    localparam int DEFAULT_PACK    = 4;
    localparam int DEFAULT_TIMEOUT = 16;

    // Number of bits needed to index n distinct values (n >= 1).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Holds 0..DEFAULT_PACK inclusive.
    typedef logic [clog2(DEFAULT_PACK + 1)-1:0] count_t;

endpackage

// File: rtl/fifo_rd_packer_if.sv
// rtl/fifo_rd_packer_if.sv - FIFO read port plus packed-word output stream
// Purpose: bundles the FIFO pop handshake and the downstream valid/ready stream.
// Signals: fifo_empty, fifo_rd_en, fifo_data[WIDTH] (registered read, 1-cycle latency);
//          m_data[WIDTH*PACK], m_valid, m_ready, m_bytes[clog2(PACK+1)].
// Modports: master = packer side, slave = FIFO/downstream side.
interface fifo_rd_packer_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int PACK  = DEFAULT_PACK
);
    localparam int BW = clog2(PACK + 1);

    logic                    fifo_empty;
    logic                    fifo_rd_en;
    logic [WIDTH-1:0]        fifo_data;
    logic [WIDTH*PACK-1:0]   m_data;
    logic                    m_valid;
    logic                    m_ready;
    logic [BW-1:0]           m_bytes;

    modport master (
        input  fifo_empty, fifo_data, m_ready,
        output fifo_rd_en, m_data, m_valid, m_bytes
    );

    modport slave (
        output fifo_empty, fifo_data, m_ready,
        input  fifo_rd_en, m_data, m_valid, m_bytes
    );

endinterface

// File: rtl/fifo_rd_outreg.sv
// rtl/fifo_rd_outreg.sv - one-entry valid/ready output register with hold under stall
// Purpose: holds one packed word; data/bytes stay stable while valid && !ready.
// Ports:   rd_clk, reset (async, active-high); load_i/data_i/bytes_i load a word
//          (caller only loads when free_o); ready_i downstream accept;
//          valid_o/data_o/bytes_o stream outputs; free_o = register can take a load now.
module fifo_rd_outreg
    import fifo_pkg::*;
#(
    parameter int DW = DEFAULT_WIDTH * DEFAULT_PACK,
    parameter int BW = clog2(DEFAULT_PACK + 1)
) (
    input  logic          rd_clk,
    input  logic          reset,
    input  logic          load_i,
    input  logic [DW-1:0] data_i,
    input  logic [BW-1:0] bytes_i,
    input  logic          ready_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic [BW-1:0] bytes_o,
    output logic          free_o
);
    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;
    logic [BW-1:0] bytes_q, bytes_d;

    // An accept in the same cycle frees the slot, so a load can chain directly.
    assign free_o = !valid_q || ready_i;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        bytes_d = bytes_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            bytes_d = bytes_i;
        end else if (ready_i) begin
            // Data/bytes are left as-is after an accept; only valid drops.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge rd_clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            bytes_q <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            bytes_q <= bytes_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign bytes_o = bytes_q;

endmodule

// File: rtl/fifo_rd_packer.sv
// rtl/fifo_rd_packer.sv - pops FIFO entries and packs PACK of them into one output word
// Purpose: read-domain consumer of the async FIFO. Pops through a registered-read port,
//          assembles PACK entries (first popped in the low lane) and hands the word to a
//          one-entry output register. Optional macro FIFO_RD_PACKER_TIMEOUT_EN adds an
//          idle counter that flushes a partial word after TIMEOUT idle cycles.
// Ports:   rd_clk  read-domain clock
//          reset   asynchronous active-high reset
//          bus     fifo_rd_packer_if.master (FIFO read port + m_* output stream)
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int PACK    = DEFAULT_PACK,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic             rd_clk,
    input  logic             reset,
    fifo_rd_packer_if.master bus
);
    localparam int CW = clog2(PACK + 1);
    localparam int LW = clog2(PACK);
    localparam int DW = WIDTH * PACK;
    localparam logic [CW-1:0] PACK_C = CW'(PACK);

    logic [CW-1:0]                fill_q, fill_d;
    logic                         inflight_q;
    logic [PACK-1:0][WIDTH-1:0]   asm_q, asm_d;
    logic                         rd_en;
    logic                         load;
    logic [DW-1:0]                load_data;
    logic [CW-1:0]                load_bytes;
    logic                         out_free;

    // Entries already in the assembly plus the one in flight must never exceed
    // PACK, so a full assembly waiting on backpressure stops popping.
    assign rd_en          = !bus.fifo_empty && ((int'(fill_q) + int'(inflight_q)) < PACK);
    assign bus.fifo_rd_en = rd_en;

`ifdef FIFO_RD_PACKER_TIMEOUT_EN
    localparam int TW = clog2(TIMEOUT + 1);

    logic [TW-1:0] idle_q, idle_d;
    logic          flush;

    always_comb begin
        flush  = (idle_q == TW'(TIMEOUT));
        idle_d = idle_q;
        if (inflight_q || fill_q == '0) begin
            idle_d = '0;
        end else if (flush) begin
            // Saturate at TIMEOUT until the output register can take the partial word.
            idle_d = out_free ? '0 : idle_q;
        end else if (bus.fifo_empty) begin
            idle_d = idle_q + TW'(1);
        end
    end

    always_ff @(posedge rd_clk or posedge reset) begin
        if (reset) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    always_comb begin
        fill_d     = fill_q;
        asm_d      = asm_q;
        load       = 1'b0;
        load_data  = asm_q;
        load_bytes = PACK_C;
        if (inflight_q) begin
            asm_d[fill_q[LW-1:0]] = bus.fifo_data;
            fill_d                = fill_q + CW'(1);
        end
        if (fill_d == PACK_C) begin
            // Covers both a completing arrival and a full assembly held by backpressure.
            if (out_free) begin
                load      = 1'b1;
                load_data = asm_d;
                asm_d     = '0;
                fill_d    = '0;
            end
        end
`ifdef FIFO_RD_PACKER_TIMEOUT_EN
        else if (flush && !inflight_q && out_free) begin
            // Lanes are cleared on every load, so unused lanes of a partial word are zero.
            load       = 1'b1;
            load_data  = asm_q;
            load_bytes = fill_q;
            asm_d      = '0;
            fill_d     = '0;
        end
`endif
    end

    always_ff @(posedge rd_clk or posedge reset) begin
        if (reset) begin
            fill_q     <= '0;
            inflight_q <= 1'b0;
            asm_q      <= '0;
        end else begin
            fill_q     <= fill_d;
            inflight_q <= rd_en;
            asm_q      <= asm_d;
        end
    end

    fifo_rd_outreg #(
        .DW (DW),
        .BW (CW)
    ) u_outreg (
        .rd_clk  (rd_clk),
        .reset   (reset),
        .load_i  (load),
        .data_i  (load_data),
        .bytes_i (load_bytes),
        .ready_i (bus.m_ready),
        .valid_o (bus.m_valid),
        .data_o  (bus.m_data),
        .bytes_o (bus.m_bytes),
        .free_o  (out_free)
    );

endmodule
